// File: rtl/rgb_mnist_downscale.sv
// rgb_mnist_downscale: RGB pixel stream -> luma -> square crop -> box average -> 28x28 byte image -> ready/valid stream.
// Latency: image write 1 cycle after the pixel; m_tvalid rises 3 cycles after the pixel closing block (27,27).
// Backpressure: none on the pixel input; output holds m_tdata/m_tlast while m_tvalid is high and m_tready is low.
module rgb_mnist_downscale #(
   parameter int CROP_X0  = 48,
   parameter int CROP_Y0  = 8,
   parameter int BLK_LOG2 = 3,
   parameter bit INVERT   = 1'b1
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        frame_start_i,
   input  logic [29:0] rgb10,
   input  logic        dat_valid,
   output logic [7:0]  m_tdata,
   output logic        m_tvalid,
   input  logic        m_tready,
   output logic        m_tlast,
   output logic        busy,
   output logic        frame_dropped
);

   localparam int BLK  = 1 << BLK_LOG2;
   localparam int CW   = 28 * BLK;
   localparam int AW   = 10 + 2 * BLK_LOG2;
   localparam int SH   = 2 * BLK_LOG2 + 2;
   localparam int NPIX = 784;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_OUT   = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [10:0]   x_q, x_d;
   logic [9:0]    y_q, y_d;
   logic          dv_q, dv_d;
   logic [AW-1:0] acc_q [28];
   logic [7:0]    img_q [NPIX];
   logic          arm_q;
   logic [9:0]    rd_idx_q, rd_idx_d;
   logic [7:0]    tdata_q, tdata_d;
   logic          tvalid_q, tvalid_d;
   logic          tlast_q, tlast_d;
   logic          drop_q, drop_d;

   logic [11:0]   luma_sum;
   logic [9:0]    luma;
   logic [11:0]   xe, ye, dx, dy;
   logic [11:0]   col_full, row_full, sc, sr;
   logic [4:0]    col, row;
   logic          in_x, in_y, pix_en;
   logic          blk_first, blk_last, wr_en, final_wr;
   logic [9:0]    wr_addr;
   logic [AW-1:0] acc_sum, avg_full;
   logic [7:0]    avg, wr_val;
   logic          xfer, load;
   logic          unused_bits;

   // Line/column position: x counts valid pixels, falling edge of dat_valid ends a line.
   always_comb begin
      x_d  = x_q;
      y_d  = y_q;
      dv_d = dat_valid;
      if (frame_start_i) begin
         x_d  = '0;
         y_d  = '0;
         dv_d = 1'b0;
      end else if (dat_valid) begin
         x_d = x_q + 11'd1;
      end else if (dv_q) begin
         x_d = '0;
         y_d = y_q + 10'd1;
      end
   end

   // Position counter registers.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         x_q  <= '0;
         y_q  <= '0;
         dv_q <= 1'b0;
      end else begin
         x_q  <= x_d;
         y_q  <= y_d;
         dv_q <= dv_d;
      end
   end

   // Luma weights 1:2:1 so the divide is a plain shift.
   assign luma_sum = 12'(rgb10[29:20]) + {1'b0, rgb10[19:10], 1'b0} + 12'(rgb10[9:0]);
   assign luma     = luma_sum[11:2];

   // Crop window and block coordinates.
   assign xe       = 12'(x_q);
   assign ye       = 12'(y_q);
   assign in_x     = (xe >= 12'(CROP_X0)) && (xe < 12'(CROP_X0 + CW));
   assign in_y     = (ye >= 12'(CROP_Y0)) && (ye < 12'(CROP_Y0 + CW));
   assign dx       = xe - 12'(CROP_X0);
   assign dy       = ye - 12'(CROP_Y0);
   assign col_full = dx >> BLK_LOG2;
   assign row_full = dy >> BLK_LOG2;
   assign col      = col_full[4:0];
   assign row      = row_full[4:0];
   assign sc       = dx & 12'(BLK - 1);
   assign sr       = dy & 12'(BLK - 1);

   assign pix_en    = (state_q == S_ACCUM) && dat_valid && in_x && in_y;
   assign blk_first = (sc == 12'd0) && (sr == 12'd0);
   assign blk_last  = (sc == 12'(BLK - 1)) && (sr == 12'(BLK - 1));
   assign wr_en     = pix_en && blk_last;
   assign final_wr  = wr_en && (row == 5'd27) && (col == 5'd27);
   assign wr_addr   = 10'(row) * 10'd28 + 10'(col);

   // The closing pixel of a block is folded in combinationally so the write lands one cycle later.
   assign acc_sum  = acc_q[col] + AW'(luma);
   assign avg_full = acc_sum >> SH;
   assign avg      = avg_full[7:0];
   assign wr_val   = INVERT ? (8'd255 - avg) : avg;

   assign unused_bits = ^{luma_sum[1:0], col_full[11:5], row_full[11:5], avg_full[AW-1:8]};

   // Per-column box accumulators: the first pixel of a block loads, the rest add.
   always_ff @(posedge Clk) begin
      if (pix_en) begin
         acc_q[col] <= blk_first ? AW'(luma) : acc_sum;
      end
   end

   // Image buffer write at the last pixel of each block.
   always_ff @(posedge Clk) begin
      if (wr_en) begin
         img_q[wr_addr] <= wr_val;
      end
   end

   // Output register: refill whenever empty or being consumed; arm_q adds the settle cycle after entering OUT.
   assign xfer = tvalid_q && m_tready;
   assign load = (state_q == S_OUT) && arm_q && (rd_idx_q != 10'(NPIX)) && (!tvalid_q || m_tready);

   // Output stage next state.
   always_comb begin
      rd_idx_d = rd_idx_q;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      if (state_q != S_OUT) begin
         rd_idx_d = '0;
      end
      if (load) begin
         tdata_d  = img_q[rd_idx_q];
         tvalid_d = 1'b1;
         tlast_d  = (rd_idx_q == 10'(NPIX - 1));
         rd_idx_d = rd_idx_q + 10'd1;
      end else if (xfer) begin
         tvalid_d = 1'b0;
         tlast_d  = 1'b0;
      end
   end

   // FSM next state; a frame start that cannot be honoured is reported as dropped.
   always_comb begin
      state_d = state_q;
      drop_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (frame_start_i) state_d = S_ACCUM;
         end
         S_ACCUM: begin
            if (final_wr) begin
               state_d = S_OUT;
               drop_d  = frame_start_i;
            end else if (frame_start_i) begin
               state_d = S_ACCUM;
            end
         end
         S_OUT: begin
            drop_d = frame_start_i;
            if (xfer && tlast_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM and output registers.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q  <= S_IDLE;
         arm_q    <= 1'b0;
         rd_idx_q <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         arm_q    <= (state_q == S_OUT);
         rd_idx_q <= rd_idx_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         drop_q   <= drop_d;
      end
   end

   assign m_tdata       = tdata_q;
   assign m_tvalid      = tvalid_q;
   assign m_tlast       = tlast_q;
   assign frame_dropped = drop_q;
   assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_rgb_mnist_downscale.sv
// Testbench for rgb_mnist_downscale: small 64x60 frames, 56x56 crop (2x2 boxes).
// Two instances share stimulus: one with INVERT=0, one with INVERT=1.
// Expected images come from a per-pixel luma/box-average model.
`timescale 1ns/1ps
module tb_rgb_mnist_downscale;

   localparam int X0    = 4;
   localparam int Y0    = 2;
   localparam int BL    = 1;
   localparam int FW    = 64;
   localparam int FH    = 60;
   localparam int LASTX = X0 + 55;
   localparam int LASTY = Y0 + 55;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        frame_start_i = 1'b0;
   logic        dat_valid = 1'b0;
   logic        m_tready = 1'b0;
   logic [29:0] rgb10 = '0;
   logic [7:0]  tdata_r, tdata_v;
   logic        tvalid_r, tvalid_v, tlast_r, tlast_v;
   logic        busy_r, busy_v, drop_r, drop_v;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int last_pix_cyc = 0;
   int drop_cnt_r = 0;
   int drop_cnt_v = 0;
   int exp_img [784];

   rgb_mnist_downscale #(.CROP_X0(X0), .CROP_Y0(Y0), .BLK_LOG2(BL), .INVERT(1'b0)) u_raw (
      .Clk(Clk), .Rst(Rst), .frame_start_i(frame_start_i), .rgb10(rgb10), .dat_valid(dat_valid),
      .m_tdata(tdata_r), .m_tvalid(tvalid_r), .m_tready(m_tready), .m_tlast(tlast_r),
      .busy(busy_r), .frame_dropped(drop_r));

   rgb_mnist_downscale #(.CROP_X0(X0), .CROP_Y0(Y0), .BLK_LOG2(BL), .INVERT(1'b1)) u_inv (
      .Clk(Clk), .Rst(Rst), .frame_start_i(frame_start_i), .rgb10(rgb10), .dat_valid(dat_valid),
      .m_tdata(tdata_v), .m_tvalid(tvalid_v), .m_tready(m_tready), .m_tlast(tlast_v),
      .busy(busy_v), .frame_dropped(drop_v));

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;
   always @(negedge Clk) if (drop_r) drop_cnt_r <= drop_cnt_r + 1;
   always @(negedge Clk) if (drop_v) drop_cnt_v <= drop_cnt_v + 1;

   task automatic chk(input string tag, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, want, $time);
      end
   endtask

   // Pixel patterns: 0 uniform grey, 1 magenta, 2 block gradient on G, 3 varied per pixel.
   function automatic logic [29:0] pix(input int mode, input int x, input int y);
      int r, g, b;
      case (mode)
         0: begin r = 512; g = 512; b = 512; end
         1: begin r = 1023; g = 0; b = 1023; end
         2: begin
            r = 0; b = 0;
            if (x >= X0 && x < X0 + 56 && y >= Y0 && y < Y0 + 56)
               g = (4 * (((y - Y0) / 2) * 28 + (x - X0) / 2)) % 1024;
            else
               g = 0;
         end
         default: begin
            r = (x * 37 + y * 11) % 1024;
            g = (x * 5 + y * 71) % 1024;
            b = (x * y * 3) % 1024;
         end
      endcase
      return {r[9:0], g[9:0], b[9:0]};
   endfunction

   task automatic build_exp(input int mode);
      logic [29:0] p;
      for (int i = 0; i < 784; i++) begin
         int s;
         s = 0;
         for (int dy = 0; dy < 2; dy++) begin
            for (int dx = 0; dx < 2; dx++) begin
               p = pix(mode, X0 + 2 * (i % 28) + dx, Y0 + 2 * (i / 28) + dy);
               s += (int'(p[29:20]) + 2 * int'(p[19:10]) + int'(p[9:0])) >> 2;
            end
         end
         exp_img[i] = s >> 4;
      end
   endtask

   task automatic send_frame(input int mode);
      @(posedge Clk); #1;
      frame_start_i = 1'b1;
      dat_valid = 1'b0;
      @(posedge Clk); #1;
      frame_start_i = 1'b0;
      chk("busy_after_start", int'(busy_r), 1);
      for (int y = 0; y < FH; y++) begin
         for (int x = 0; x < FW; x++) begin
            rgb10 = pix(mode, x, y);
            dat_valid = 1'b1;
            if (x == LASTX && y == LASTY) last_pix_cyc = cyc;
            @(posedge Clk); #1;
         end
         dat_valid = 1'b0;
         rgb10 = '0;
         @(posedge Clk); #1;
         @(posedge Clk); #1;
      end
   endtask

   task automatic collect(input bit rnd, input int fs_at, input int rst_at);
      int n = 0;
      int guard = 0;
      int first = -1;
      int prev = 0;
      bit stalled = 1'b0;
      bit fs_arm = 1'b0;
      bit fs_on = 1'b0;
      bit rst_arm = 1'b0;
      bit done = 1'b0;
      logic [7:0] held = '0;
      m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      while (!done && guard < 12000) begin
         @(negedge Clk);
         guard++;
         if (stalled) begin
            chk("stall_hold_valid", int'(tvalid_r), 1);
            chk("stall_hold_data", int'(tdata_r), int'(held));
         end
         stalled = tvalid_r && !m_tready;
         held = tdata_r;
         if (tvalid_r && first < 0) begin
            first = cyc;
            chk("first_valid_latency", first - last_pix_cyc, 3);
         end
         if (tvalid_r && m_tready) begin
            chk("pix_raw", int'(tdata_r), exp_img[n]);
            chk("pix_inv", int'(tdata_v), 255 - exp_img[n]);
            chk("tlast_raw", int'(tlast_r), int'(n == 783));
            chk("tlast_inv", int'(tlast_v), int'(n == 783));
            if (!rnd && n > 0) chk("back_to_back", cyc - prev, 1);
            prev = cyc;
            if (n == fs_at) fs_arm = 1'b1;
            if (n == rst_at) rst_arm = 1'b1;
            n++;
            if (n == 784) done = 1'b1;
         end
         @(posedge Clk); #1;
         if (rnd) m_tready = 1'($urandom_range(0, 1));
         if (fs_arm) begin
            frame_start_i = 1'b1;
            fs_arm = 1'b0;
            fs_on = 1'b1;
         end else if (fs_on) begin
            frame_start_i = 1'b0;
            fs_on = 1'b0;
         end
         if (rst_arm) begin
            Rst = 1'b1;
            @(posedge Clk); #1;
            Rst = 1'b0;
            @(negedge Clk);
            chk("rst_tvalid", int'(tvalid_r), 0);
            chk("rst_busy", int'(busy_r), 0);
            chk("rst_tvalid_inv", int'(tvalid_v), 0);
            done = 1'b1;
         end
      end
      if (fs_on) frame_start_i = 1'b0;
      if (rst_at < 0) begin
         chk("stream_count", n, 784);
         @(negedge Clk);
         chk("tvalid_after_last", int'(tvalid_r), 0);
         chk("idle_after_last", int'(busy_r), 0);
         chk("idle_after_last_inv", int'(busy_v), 0);
      end else begin
         chk("transfers_before_rst", n, rst_at + 1);
      end
   endtask

   task automatic run(input int mode, input bit rnd, input int fs_at, input int rst_at);
      int d_r, d_v;
      build_exp(mode);
      d_r = drop_cnt_r;
      d_v = drop_cnt_v;
      fork
         send_frame(mode);
         collect(rnd, fs_at, rst_at);
      join
      @(negedge Clk);
      chk("drop_pulses_raw", drop_cnt_r - d_r, (fs_at >= 0) ? 1 : 0);
      chk("drop_pulses_inv", drop_cnt_v - d_v, (fs_at >= 0) ? 1 : 0);
   endtask

   initial begin
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      chk("rst_m_tvalid", int'(tvalid_r), 0);
      chk("rst_m_tlast", int'(tlast_r), 0);
      chk("rst_m_tdata", int'(tdata_r), 0);
      chk("rst_busy", int'(busy_r), 0);
      chk("rst_frame_dropped", int'(drop_r), 0);
      chk("rst_m_tvalid_inv", int'(tvalid_v), 0);
      chk("rst_busy_inv", int'(busy_v), 0);
      chk("rst_frame_dropped_inv", int'(drop_v), 0);
      @(posedge Clk); #1;
      Rst = 1'b0;

      run(0, 1'b0, -1, -1);   // uniform grey: raw 0x80, inverted 0x7F
      run(1, 1'b0, -1, -1);   // magenta: Y=511, raw 0x7F
      run(2, 1'b0, -1, -1);   // block gradient: pixel i = (4i mod 1024) >> 3
      run(3, 1'b1, -1, -1);   // varied pixels, random backpressure
      run(0, 1'b0, 100, -1);  // frame start during streaming is dropped
      run(3, 1'b1, -1, 400);  // reset mid-stream
      run(0, 1'b0, -1, -1);   // fresh frame after reset

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
